// File: rtl/mcdf_arbiter_if.sv
// Configuration, FIFO-level and formatter handshake bundle for the MCDF packet arbiter.
// master = arbiter side, slave = register block / FIFOs / formatter side.
interface mcdf_arbiter_if #(
  parameter int CNT_W = 6
);
  logic             slv0_en;
  logic             slv1_en;
  logic             slv2_en;
  logic [1:0]       slv0_prio;
  logic [1:0]       slv1_prio;
  logic [1:0]       slv2_prio;
  logic [2:0]       slv0_len;
  logic [2:0]       slv1_len;
  logic [2:0]       slv2_len;
  logic [CNT_W-1:0] slv0_cnt;
  logic [CNT_W-1:0] slv1_cnt;
  logic [CNT_W-1:0] slv2_cnt;
  logic             slv0_pop;
  logic             slv1_pop;
  logic             slv2_pop;
  logic             fmt_req;
  logic [1:0]       fmt_ch;
  logic [5:0]       fmt_len;
  logic             fmt_grant;
  logic             fmt_rdy;
  logic             pkt_done;

  modport master (
    input  slv0_en, slv1_en, slv2_en,
    input  slv0_prio, slv1_prio, slv2_prio,
    input  slv0_len, slv1_len, slv2_len,
    input  slv0_cnt, slv1_cnt, slv2_cnt,
    output slv0_pop, slv1_pop, slv2_pop,
    output fmt_req, fmt_ch, fmt_len,
    input  fmt_grant, fmt_rdy,
    output pkt_done
  );

  modport slave (
    output slv0_en, slv1_en, slv2_en,
    output slv0_prio, slv1_prio, slv2_prio,
    output slv0_len, slv1_len, slv2_len,
    output slv0_cnt, slv1_cnt, slv2_cnt,
    input  slv0_pop, slv1_pop, slv2_pop,
    input  fmt_req, fmt_ch, fmt_len,
    output fmt_grant, fmt_rdy,
    input  pkt_done
  );
endinterface

// File: rtl/mcdf_arbiter.sv
// Three-channel MCDF packet arbiter: priority + round-robin selection, req/grant, word pops.
// Optional starvation promotion is built when MCDF_ARB_STARVE_EN is defined.
module mcdf_arbiter #(
  parameter int CNT_W        = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rstn,
  mcdf_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } state_t;

  function automatic logic [5:0] decode_len(input logic [2:0] code);
    logic [5:0] words;
    case (code)
      3'd0:    words = 6'd1;
      3'd1:    words = 6'd2;
      3'd2:    words = 6'd4;
      3'd3:    words = 6'd8;
      default: words = 6'd32;
    endcase
    return words;
  endfunction

  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

  // Index 3 is a tied-off phantom channel so 2-bit channel ids always index in range.
  logic [3:0]       en;
  logic [1:0]       prio     [3];
  logic [2:0]       len_code [3];
  logic [CNT_W-1:0] cnt      [3];
  logic [5:0]       dec_len  [4];
  logic [3:0]       eligible;
  logic [2:0]       starved;
  logic [2:0]       key      [3];
  logic             any_elig;

  assign en       = {1'b0, bus.slv2_en, bus.slv1_en, bus.slv0_en};
  assign prio     = '{bus.slv0_prio, bus.slv1_prio, bus.slv2_prio};
  assign len_code = '{bus.slv0_len, bus.slv1_len, bus.slv2_len};
  assign cnt      = '{bus.slv0_cnt, bus.slv1_cnt, bus.slv2_cnt};

  assign dec_len[3]  = 6'd0;
  assign eligible[3] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      assign dec_len[gi]  = decode_len(len_code[gi]);
      assign eligible[gi] = en[gi] && (int'(cnt[gi]) >= int'(dec_len[gi]));
      // A starved channel outranks every non-starved one, whatever its programmed priority.
      assign key[gi]      = starved[gi] ? 3'b000 : {1'b1, prio[gi]};
    end
  endgenerate

  assign any_elig = |eligible[2:0];

  state_t     state_reg, state_next;
  logic [1:0] win_reg,   win_next;
  logic [5:0] len_reg,   len_next;
  logic [5:0] beat_reg,  beat_next;
  logic [1:0] last_reg,  last_next;

  logic [2:0] best_key;
  logic       best_found;
  logic [1:0] sel;
  logic       sel_found;
  logic [1:0] rr_idx;

  always_comb begin
    best_key   = 3'b111;
    best_found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (eligible[i] && (!best_found || key[i] < best_key)) begin
        best_key   = key[i];
        best_found = 1'b1;
      end
    end
  end

  // Among channels sharing the best key, scan from the one after the last winner.
  always_comb begin
    sel       = 2'd0;
    sel_found = 1'b0;
    rr_idx    = next_ch(last_reg);
    for (int k = 0; k < 3; k++) begin
      if (!sel_found && eligible[rr_idx] && key[rr_idx[1:0] == 2'd3 ? 0 : rr_idx] == best_key) begin
        sel       = rr_idx;
        sel_found = 1'b1;
      end
      rr_idx = next_ch(rr_idx);
    end
  end

`ifdef MCDF_ARB_STARVE_EN
  localparam int LOSS_W = $clog2(STARVE_LIMIT + 1);

  logic leave_idle;
  assign leave_idle = (state_reg == IDLE) && any_elig;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_loss
      logic [LOSS_W-1:0] loss_reg;

      assign starved[gi] = (int'(loss_reg) >= STARVE_LIMIT);

      // Losses are tallied only at selection events, saturating at the limit.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          loss_reg <= '0;
        end else if (leave_idle) begin
          if (sel == 2'(gi) || !eligible[gi]) begin
            loss_reg <= '0;
          end else if (!starved[gi]) begin
            loss_reg <= loss_reg + LOSS_W'(1);
          end
        end
      end
    end
  endgenerate
`else
  // No loss counters in this build; the comparison folds to a constant 0.
  assign starved = {3{STARVE_LIMIT < 0}};
`endif

  logic [2:0] pop_vec;
  logic       req;
  logic       done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      win_reg   <= 2'd0;
      len_reg   <= 6'd0;
      beat_reg  <= 6'd0;
      last_reg  <= 2'd2;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      len_reg   <= len_next;
      beat_reg  <= beat_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    len_next   = len_reg;
    beat_next  = beat_reg;
    last_next  = last_reg;
    pop_vec    = 3'b000;
    req        = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_elig) begin
          state_next = REQ;
          win_next   = sel;
          len_next   = dec_len[sel];
          beat_next  = dec_len[sel];
        end
      end
      REQ: begin
        req = 1'b1;
        // An accepted grant takes precedence over a same-cycle enable drop.
        if (bus.fmt_grant) begin
          state_next = BURST;
          last_next  = win_reg;
        end else if (!en[win_reg]) begin
          state_next = IDLE;
        end
      end
      BURST: begin
        if (bus.fmt_rdy) begin
          pop_vec[win_reg] = 1'b1;
          beat_next        = beat_reg - 6'd1;
          if (beat_reg == 6'd1) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.slv0_pop = pop_vec[0];
  assign bus.slv1_pop = pop_vec[1];
  assign bus.slv2_pop = pop_vec[2];
  assign bus.fmt_req  = req;
  assign bus.fmt_ch   = win_reg;
  assign bus.fmt_len  = len_reg;
  assign bus.pkt_done = done;

endmodule

// File: doc/mcdf_arbiter.md
Name: mcdf_arbiter

Overview:
- Three-channel packet arbiter for the multi-channel data formatter.
- Consumes the per-slave register-block configuration (enable, priority, packet length) plus each slave FIFO's fill count, and picks one channel per packet.
- Holds a request/grant handshake with the formatter, then sequences word pops from the winning slave FIFO until the packet completes.

Parameters:
- CNT_W, 6, width of slave FIFO fill counts (0..63 words).
- STARVE_LIMIT, 4, consecutive lost arbitrations before promotion (used only with MCDF_ARB_STARVE_EN).

Ports:
- clk  input  1  single clock.
- rstn  input  1  asynchronous active-low reset.
- slv0_en / slv1_en / slv2_en  input  1 each  channel enable from the register block.
- slv0_prio / slv1_prio / slv2_prio  input  2 each  priority; 0 is highest.
- slv0_len / slv1_len / slv2_len  input  3 each  packet length code.
- slv0_cnt / slv1_cnt / slv2_cnt  input  CNT_W each  words currently buffered in the slave FIFO.
- slv0_pop / slv1_pop / slv2_pop  output  1 each  pop one word from the slave FIFO this cycle.
- fmt_req  output  1  packet request to the formatter.
- fmt_ch  output  2  granted channel id (0..2).
- fmt_len  output  6  decoded packet length in words.
- fmt_grant  input  1  formatter accepts the request.
- fmt_rdy  input  1  formatter can take one word this cycle.
- pkt_done  output  1  one-cycle pulse on the last word of a packet.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0. FSM goes to IDLE, beat counter 0, last-winner pointer = 2 so channel 0 wins the first tie.
- Length decode: 0->1, 1->2, 2->4, 3->8, 4..7->32 words, zero-extended to 6 bits.
- Eligibility (combinational): slvN_en == 1 and slvN_cnt >= decoded length of slvN_len.
- Winner selection:
  - Lowest prio value among eligible channels.
  - Ties are broken round-robin, starting at (last winner + 1) mod 3.
- FSM:
  - IDLE: if any channel is eligible, register the winner, its decoded length and the beat counter (= length), then go to REQ. No request is issued in the cycle of entry.
  - REQ: fmt_req = 1; fmt_ch and fmt_len are held stable.
    - fmt_grant = 1 -> go to BURST and update the last-winner pointer.
    - Winner's slvN_en drops before grant -> go to IDLE; fmt_req goes low the next cycle; pointer is not updated.
    - fmt_grant is ignored in every state except REQ.
  - BURST: fmt_req = 0.
    - slvN_pop[winner] = fmt_rdy (combinational, same cycle); all other pops stay 0.
    - The beat counter decrements on each fmt_rdy cycle.
    - On the fmt_rdy cycle where the counter equals 1, pkt_done pulses and the FSM goes to IDLE.
    - fmt_rdy low stalls with no pop; there is no timeout.
- Minimum latency: eligible in cycle t -> fmt_req at t+1. If fmt_grant arrives at t+1, the first pop can occur at t+2.
- Back-to-back packets: IDLE always lasts at least one cycle after pkt_done; there is one bubble between packets.
- Input changes:
  - Changes to en/prio/len during REQ (other than the en drop above) or BURST do not alter the current packet.
  - Disabling the winner mid-burst does not abort it; the packet completes.
- The FIFO count is trusted. The block does not check underflow during a burst (eligibility guarantees enough words at selection time).
- Reset asserted mid-packet: the packet is abandoned immediately and all pops are 0 while rstn = 0.

Optional Feature:
- MCDF_ARB_STARVE_EN defined:
  - Per channel, a saturating loss counter increments each time the FSM leaves IDLE with that channel eligible but not selected.
  - The counter clears when the channel wins or is not eligible.
  - A channel whose counter reaches STARVE_LIMIT is treated as prio 0 and wins ahead of any non-starved channel. Ties among starved channels use round-robin.
  - Loss counters reset to 0.
- Undefined: pure priority plus round-robin; no loss counters exist.

Test Plan:
- Single channel: slv1_en=1, prio=2, len=2, cnt=4, fmt_grant and fmt_rdy held 1 -> fmt_req at t+1 with fmt_ch=1, fmt_len=4. Four slv1_pop cycles follow, pkt_done on the 4th, then back to IDLE.
- Priority: all channels enabled, cnt=63, prio={3,0,1}, len=0 -> grant order ch1, ch1, ... while ch1 stays eligible. ch1 cnt dropped to 0 -> ch2 wins next.
- Round-robin tie: all channels prio=1, len=0, cnt=63 -> grant order 0, 1, 2, 0, 1, 2, with one idle cycle between packets.
- Handshake stall:
  - fmt_grant delayed 5 cycles -> fmt_req, fmt_ch and fmt_len are stable for all 5 cycles.
  - fmt_rdy toggled 1,0,0,1 in BURST with len=1 (2 words) -> exactly 2 pops, pkt_done on the 4th BURST cycle.
- Boundaries:
  - slv0 len=4 with cnt=31 -> not eligible; cnt=32 -> eligible with fmt_len=32.
  - slv0_en dropped in REQ -> fmt_req deasserts and the FSM returns to IDLE.
  - rstn pulled low at the 3rd of 8 beats -> pops and pkt_done are 0 immediately; after release the FSM restarts in IDLE.
- MCDF_ARB_STARVE_EN, STARVE_LIMIT=4: ch0 prio=0, ch2 prio=3, both always eligible -> ch2 is granted after 4 consecutive ch0 wins, then ch0 resumes.
